// File: rtl/cv32e40x_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40x_pkg
// Description : Shared types and constants for the event arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40x_pkg;

  // Width of the forward-progress retirement counter
  localparam int unsigned EVT_CNT_W = 4;

  // Event classes offered to the controller FSM, encoded in priority order
  typedef enum logic [1:0] {
    EVT_NMI      = 2'b00,
    EVT_DBG_REQ  = 2'b01,
    EVT_DBG_STEP = 2'b10,
    EVT_IRQ      = 2'b11
  } event_type_e;

endpackage
`default_nettype wire

// File: rtl/cv32e40x_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40x_event_arbiter
// Description : Collects NMI / debug request / single-step / interrupt
//               sources and offers one prioritized, registered event to the
//               controller FSM over a valid/ack handshake. After each taken
//               event a guard window waits for PROGRESS_CNT retirements.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40x_event_arbiter
  import cv32e40x_pkg::*;
#(
  parameter int unsigned PROGRESS_CNT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        debug_mode_i,
  input  logic        debug_req_i,
  input  logic        debug_single_step_i,
  input  logic        irq_req_ctrl_i,
  input  logic [4:0]  irq_id_ctrl_i,
  input  logic        wb_valid_i,
  input  logic        lsu_err_wb_i,
  input  logic [31:0] lsu_addr_wb_i,
  input  logic        evt_ack_i,
  output logic        evt_valid_o,
  output logic [1:0]  evt_type_o,
  output logic [4:0]  evt_cause_o,
  output logic [31:0] nmi_addr_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OFFER = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  localparam logic [EVT_CNT_W-1:0] CNT_LOAD = PROGRESS_CNT[EVT_CNT_W-1:0];

  logic [1:0]           state_q, state_d;
  logic                 nmi_pend_q, nmi_pend_d;
  logic                 dbg_pend_q, dbg_pend_d;
  logic                 step_pend_q, step_pend_d;
  logic [31:0]          nmi_addr_q, nmi_addr_d;
  logic [EVT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 evt_valid_q, evt_valid_d;
  event_type_e          evt_type_q, evt_type_d;
  logic [4:0]           evt_cause_q, evt_cause_d;

  logic                 nmi_set, dbg_set, step_set;
  logic                 ack_take, ack_nmi, ack_dbg, retract;
  logic                 eligible;
  event_type_e          win_type;
  logic [4:0]           win_cause;

  assign nmi_set  = wb_valid_i & lsu_err_wb_i;
  assign dbg_set  = debug_req_i & ~debug_mode_i;
  assign step_set = wb_valid_i & debug_single_step_i & ~debug_mode_i;

  assign ack_take = (state_q == S_OFFER) & evt_ack_i;
  assign ack_nmi  = ack_take & (evt_type_q == EVT_NMI);
  assign ack_dbg  = ack_take & ((evt_type_q == EVT_DBG_REQ) | (evt_type_q == EVT_DBG_STEP));
  // An interrupt offer is withdrawn when its level drops before being taken
  assign retract  = (state_q == S_OFFER) & (evt_type_q == EVT_IRQ) & ~irq_req_ctrl_i & ~evt_ack_i;

  // Pending-source bookkeeping; an NMI ack clears before a same-cycle error re-pends
  always_comb begin
    nmi_pend_d  = nmi_pend_q;
    nmi_addr_d  = nmi_addr_q;
    dbg_pend_d  = dbg_pend_q;
    step_pend_d = step_pend_q;
    if (ack_nmi) begin
      nmi_pend_d = 1'b0;
    end
    if (nmi_set && !nmi_pend_d) begin
      nmi_pend_d = 1'b1;
      nmi_addr_d = lsu_addr_wb_i;
    end
    // Taking a debug event absorbs any debug/step request seen in that cycle
    if (ack_dbg) begin
      dbg_pend_d  = 1'b0;
      step_pend_d = 1'b0;
    end else begin
      dbg_pend_d  = dbg_pend_q | dbg_set;
      step_pend_d = step_pend_q | step_set;
    end
  end

  // Fixed-priority winner over sources including those arriving this cycle
  always_comb begin
    win_type  = EVT_IRQ;
    win_cause = 5'd0;
    if (nmi_pend_d) begin
      win_type = EVT_NMI;
    end else if (dbg_pend_d) begin
      win_type = EVT_DBG_REQ;
    end else if (step_pend_d) begin
      win_type = EVT_DBG_STEP;
    end else begin
      win_type  = EVT_IRQ;
      win_cause = irq_id_ctrl_i;
    end
  end

  assign eligible = ~debug_mode_i & (nmi_pend_d | dbg_pend_d | step_pend_d | irq_req_ctrl_i);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (eligible) state_d = S_OFFER;
      end
      S_OFFER: begin
        if (evt_ack_i)    state_d = S_GUARD;
        else if (retract) state_d = S_IDLE;
      end
      S_GUARD: begin
        if ((cnt_q == '0) || (wb_valid_i && (cnt_q == EVT_CNT_W'(1)))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and counter next values; offers are registered so they appear a cycle later
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_type_d  = evt_type_q;
    evt_cause_d = evt_cause_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        evt_valid_d = 1'b0;
        if (eligible) begin
          evt_valid_d = 1'b1;
          evt_type_d  = win_type;
          evt_cause_d = win_cause;
        end
      end
      S_OFFER: begin
        if (evt_ack_i) begin
          evt_valid_d = 1'b0;
          cnt_d       = CNT_LOAD;
        end else if (retract) begin
          evt_valid_d = 1'b0;
        end
      end
      S_GUARD: begin
        evt_valid_d = 1'b0;
        if (wb_valid_i && (cnt_q != '0)) cnt_d = cnt_q - EVT_CNT_W'(1);
      end
      default: evt_valid_d = 1'b0;
    endcase
  end

  // Flag, address, counter and offer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_pend_q  <= 1'b0;
      dbg_pend_q  <= 1'b0;
      step_pend_q <= 1'b0;
      nmi_addr_q  <= 32'd0;
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_type_q  <= EVT_NMI;
      evt_cause_q <= 5'd0;
    end else begin
      nmi_pend_q  <= nmi_pend_d;
      dbg_pend_q  <= dbg_pend_d;
      step_pend_q <= step_pend_d;
      nmi_addr_q  <= nmi_addr_d;
      cnt_q       <= cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_type_q  <= evt_type_d;
      evt_cause_q <= evt_cause_d;
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_type_o  = evt_type_q;
  assign evt_cause_o = evt_cause_q;
  assign nmi_addr_o  = nmi_addr_q;

`ifndef SYNTHESIS
  a_ack_needs_offer: assert property (@(posedge clk) disable iff (!rst_n) evt_ack_i |-> evt_valid_o)
    else $error("evt_ack_i asserted while no event is offered");
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40x_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40x_event_arbiter
// Description : Self-checking bench for cv32e40x_event_arbiter. Two
//               instances (PROGRESS_CNT = 1 and 3) share stimulus and are
//               both tracked by an event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40x_event_arbiter;
  import cv32e40x_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        debug_mode = 1'b0;
  logic        debug_req = 1'b0;
  logic        step = 1'b0;
  logic        irq = 1'b0;
  logic [4:0]  irq_id = 5'd0;
  logic        wb = 1'b0;
  logic        err = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [1:0]  ack = 2'b00;
  logic [1:0]  ack_req = 2'b00;

  logic [1:0]  v;
  logic [1:0]  evt_type [2];
  logic [4:0]  evt_cause [2];
  logic [31:0] nmi_addr [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cv32e40x_event_arbiter #(.PROGRESS_CNT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .debug_mode_i(debug_mode), .debug_req_i(debug_req),
    .debug_single_step_i(step), .irq_req_ctrl_i(irq), .irq_id_ctrl_i(irq_id),
    .wb_valid_i(wb), .lsu_err_wb_i(err), .lsu_addr_wb_i(addr), .evt_ack_i(ack[0]),
    .evt_valid_o(v[0]), .evt_type_o(evt_type[0]), .evt_cause_o(evt_cause[0]),
    .nmi_addr_o(nmi_addr[0])
  );

  cv32e40x_event_arbiter #(.PROGRESS_CNT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .debug_mode_i(debug_mode), .debug_req_i(debug_req),
    .debug_single_step_i(step), .irq_req_ctrl_i(irq), .irq_id_ctrl_i(irq_id),
    .wb_valid_i(wb), .lsu_err_wb_i(err), .lsu_addr_wb_i(addr), .evt_ack_i(ack[1]),
    .evt_valid_o(v[1]), .evt_type_o(evt_type[1]), .evt_cause_o(evt_cause[1]),
    .nmi_addr_o(nmi_addr[1])
  );

  // ---------------- reference model (event level) ----------------
  bit          m_offer [2];
  logic [1:0]  m_type  [2];
  logic [4:0]  m_cause [2];
  int          m_guard [2];
  bit          m_nmi   [2];
  logic [31:0] m_addr  [2];
  bit          m_dbg   [2];
  bit          m_step  [2];

  function automatic int pcnt(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_offer[i] = 0; m_type[i] = EVT_NMI; m_cause[i] = 0; m_guard[i] = 0;
      m_nmi[i] = 0; m_addr[i] = 0; m_dbg[i] = 0; m_step[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit took;
    logic [1:0] tt;
    took = m_offer[i] && ack[i];
    tt   = m_type[i];
    if (took && tt == EVT_NMI) m_nmi[i] = 0;
    if (wb && err && !m_nmi[i]) begin
      m_nmi[i] = 1;
      m_addr[i] = addr;
    end
    if (took && (tt == EVT_DBG_REQ || tt == EVT_DBG_STEP)) begin
      m_dbg[i] = 0;
      m_step[i] = 0;
    end else begin
      if (debug_req && !debug_mode) m_dbg[i] = 1;
      if (wb && step && !debug_mode) m_step[i] = 1;
    end
    if (m_offer[i]) begin
      if (took) begin
        m_offer[i] = 0;
        m_guard[i] = pcnt(i);
      end else if (tt == EVT_IRQ && !irq) begin
        m_offer[i] = 0;
      end
    end else if (m_guard[i] > 0) begin
      if (wb) m_guard[i]--;
    end else if (!debug_mode) begin
      m_offer[i] = 1;
      m_cause[i] = 0;
      if (m_nmi[i])       m_type[i] = EVT_NMI;
      else if (m_dbg[i])  m_type[i] = EVT_DBG_REQ;
      else if (m_step[i]) m_type[i] = EVT_DBG_STEP;
      else if (irq) begin
        m_type[i] = EVT_IRQ;
        m_cause[i] = irq_id;
      end else m_offer[i] = 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [dut%0d] t=%0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic check_model(input int i);
    chk("valid", i, 32'(v[i]), 32'(m_offer[i]));
    if (m_offer[i]) begin
      chk("type", i, 32'(evt_type[i]), 32'(m_type[i]));
      chk("cause", i, 32'(evt_cause[i]), 32'(m_cause[i]));
    end
    chk("nmi_addr", i, nmi_addr[i], m_addr[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_valid"}, i, 32'(v[i]), 32'd0);
      chk({tag, "_type"}, i, 32'(evt_type[i]), 32'(EVT_NMI));
      chk({tag, "_cause"}, i, 32'(evt_cause[i]), 32'd0);
      chk({tag, "_addr"}, i, nmi_addr[i], 32'd0);
    end
  endtask

  // One clock: ack only goes to an instance that the model says is offering
  task automatic cycle();
    ack[0] = ack_req[0] & m_offer[0];
    ack[1] = ack_req[1] & m_offer[1];
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_model(0);
    check_model(1);
  endtask

  task automatic clear_inputs();
    debug_mode = 0; debug_req = 0; step = 0; irq = 0; irq_id = 0;
    wb = 0; err = 0; addr = 0; ack_req = 0; ack = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          irq;
    logic [4:0]  id;
    bit          wb;
    bit          err;
    logic [31:0] addr;
    bit          dreq;
    bit          ack;
    bit          ev;
    logic [1:0]  et;
    logic [4:0]  ec;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl [22];

  initial begin
    tbl = '{
      // irq take, guard of one retirement, re-offer, retract
      '{1, 11, 0, 0, 32'h0,    0, 0, 1, EVT_IRQ,     11, 32'h0},
      '{1, 11, 0, 0, 32'h0,    0, 1, 0, EVT_NMI,      0, 32'h0},
      '{1, 11, 0, 0, 32'h0,    0, 0, 0, EVT_NMI,      0, 32'h0},
      '{1, 11, 1, 0, 32'h0,    0, 0, 0, EVT_NMI,      0, 32'h0},
      '{1, 11, 0, 0, 32'h0,    0, 0, 1, EVT_IRQ,     11, 32'h0},
      '{0, 11, 0, 0, 32'h0,    0, 0, 0, EVT_NMI,      0, 32'h0},
      '{0, 0,  0, 0, 32'h0,    0, 0, 0, EVT_NMI,      0, 32'h0},
      // NMI beats same-cycle debug request and irq; sticky debug follows
      '{1, 5,  1, 1, 32'h1004, 1, 0, 1, EVT_NMI,      0, 32'h1004},
      '{1, 5,  0, 0, 32'h0,    0, 1, 0, EVT_NMI,      0, 32'h1004},
      '{1, 5,  1, 0, 32'h0,    0, 0, 0, EVT_NMI,      0, 32'h1004},
      '{1, 5,  0, 0, 32'h0,    0, 0, 1, EVT_DBG_REQ,  0, 32'h1004},
      '{1, 5,  0, 0, 32'h0,    0, 1, 0, EVT_NMI,      0, 32'h1004},
      '{1, 5,  1, 0, 32'h0,    0, 0, 0, EVT_NMI,      0, 32'h1004},
      // no preemption of an irq offer; second error keeps first address
      '{1, 3,  0, 0, 32'h0,    0, 0, 1, EVT_IRQ,      3, 32'h1004},
      '{1, 3,  1, 1, 32'h2000, 0, 0, 1, EVT_IRQ,      3, 32'h2000},
      '{1, 3,  1, 1, 32'h3000, 0, 0, 1, EVT_IRQ,      3, 32'h2000},
      '{1, 3,  0, 0, 32'h0,    0, 1, 0, EVT_NMI,      0, 32'h2000},
      '{1, 3,  1, 0, 32'h0,    0, 0, 0, EVT_NMI,      0, 32'h2000},
      '{1, 3,  0, 0, 32'h0,    0, 0, 1, EVT_NMI,      0, 32'h2000},
      '{1, 3,  0, 0, 32'h0,    0, 1, 0, EVT_NMI,      0, 32'h2000},
      '{0, 0,  1, 0, 32'h0,    0, 0, 0, EVT_NMI,      0, 32'h2000},
      '{0, 0,  0, 0, 32'h0,    0, 0, 0, EVT_NMI,      0, 32'h2000}
    };
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    do_reset();

    // Table-driven directed vectors, checked against fixed values on dut1
    for (int k = 0; k < 22; k++) begin
      irq = tbl[k].irq; irq_id = tbl[k].id; wb = tbl[k].wb; err = tbl[k].err;
      addr = tbl[k].addr; debug_req = tbl[k].dreq; ack_req = {2{tbl[k].ack}};
      cycle();
      chk($sformatf("tbl%0d_valid", k), 0, 32'(v[0]), 32'(tbl[k].ev));
      if (tbl[k].ev) begin
        chk($sformatf("tbl%0d_type", k), 0, 32'(evt_type[0]), 32'(tbl[k].et));
        chk($sformatf("tbl%0d_cause", k), 0, 32'(evt_cause[0]), 32'(tbl[k].ec));
      end
      chk($sformatf("tbl%0d_addr", k), 0, nmi_addr[0], tbl[k].ea);
    end

    // Debug mode masks everything and blocks debug/step from pending
    do_reset();
    debug_mode = 1; irq = 1; debug_req = 1;
    cycle();
    cycle();
    chk("mask_valid", 0, 32'(v[0]), 32'd0);
    debug_mode = 0; irq = 0; debug_req = 0;
    cycle();
    chk("mask_nodbg", 0, 32'(v[0]), 32'd0);
    step = 1; wb = 1;
    cycle();
    chk("step_valid", 0, 32'(v[0]), 32'd1);
    chk("step_type", 0, 32'(evt_type[0]), 32'(EVT_DBG_STEP));
    step = 0; wb = 0; ack_req = 2'b11;
    cycle();
    chk("step_ack", 0, 32'(v[0]), 32'd0);
    ack_req = 2'b00; wb = 1;
    for (int k = 0; k < 4; k++) cycle();
    wb = 0;
    cycle();
    chk("step_cleared", 0, 32'(v[0]), 32'd0);

    // PROGRESS_CNT = 3 guard window, then asynchronous reset mid-offer
    do_reset();
    irq = 1; irq_id = 7;
    cycle();
    chk("p3_offer", 1, 32'(v[1]), 32'd1);
    ack_req = 2'b11;
    cycle();
    ack_req = 2'b00; wb = 1;
    cycle();
    cycle();
    chk("p3_wb2", 1, 32'(v[1]), 32'd0);
    cycle();
    chk("p3_wb3", 1, 32'(v[1]), 32'd0);
    wb = 0;
    cycle();
    chk("p3_reoffer", 1, 32'(v[1]), 32'd1);
    chk("p3_cause", 1, 32'(evt_cause[1]), 32'd7);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_reset_vals("async_rst");
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) irq = ~irq;
      irq_id     = 5'($urandom_range(0, 31));
      debug_mode = ($urandom_range(0, 15) == 0);
      debug_req  = ($urandom_range(0, 31) == 0);
      step       = ($urandom_range(0, 7) == 0);
      wb         = ($urandom_range(0, 1) == 1);
      err        = ($urandom_range(0, 5) == 0);
      addr       = $urandom;
      ack_req    = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cv32e40x_event_arbiter.md
Name: cv32e40x_event_arbiter

Overview:
- Collects asynchronous core events (NMI from a WB bus error, external debug request, single-step trap, interrupt) and presents one prioritized, registered event offer to cv32e40x_controller_fsm via a valid/ack handshake.
- Enforces forward progress: after an event is taken, a new offer is blocked until PROGRESS_CNT instructions retire.
- Sits between the interrupt controller/WB stage and the controller FSM, inside cv32e40x_controller.

Parameters:
- PROGRESS_CNT, 1, number of retired instructions (wb_valid_i pulses) required after an ack before the next offer; legal range 1..15.

Ports:
- clk  in  1  gated core clock
- rst_n  in  1  asynchronous active-low reset
- debug_mode_i  in  1  core is in debug mode
- debug_req_i  in  1  external debug request (level)
- debug_single_step_i  in  1  dcsr.step
- irq_req_ctrl_i  in  1  enabled interrupt pending (level)
- irq_id_ctrl_i  in  5  interrupt id
- wb_valid_i  in  1  instruction retires in WB this cycle
- lsu_err_wb_i  in  1  LSU bus error on the WB instruction
- lsu_addr_wb_i  in  32  address of the faulting access
- evt_ack_i  in  1  FSM takes the offered event this cycle
- evt_valid_o  out  1  event offered
- evt_type_o  out  2  event_type_e: EVT_NMI, EVT_DBG_REQ, EVT_DBG_STEP, EVT_IRQ
- evt_cause_o  out  5  irq id for EVT_IRQ; 0 otherwise
- nmi_addr_o  out  32  captured fault address, valid while an NMI is pending

Behaviour:
- Reset: state IDLE. evt_valid_o=0, evt_type_o=EVT_NMI (2'b00), evt_cause_o=0, nmi_addr_o=0. All pending flags and the counter are 0.
- Pending sources:
  - nmi_pend sets on wb_valid_i&lsu_err_wb_i, capturing lsu_addr_wb_i. A further error while nmi_pend=1 is ignored and keeps the first address. nmi_pend clears only on ack of EVT_NMI.
  - dbg_pend sets on debug_req_i=1 while debug_mode_i=0 and stays sticky after debug_req_i falls. It clears on ack of EVT_DBG_REQ or EVT_DBG_STEP.
  - step_pend sets on wb_valid_i&debug_single_step_i&!debug_mode_i. It clears on ack of EVT_DBG_REQ or EVT_DBG_STEP.
  - The irq source is the live level irq_req_ctrl_i and is not latched.
- Priority: NMI > DBG_REQ > DBG_STEP > IRQ.
- Masking: while debug_mode_i=1, nothing is offered. Pending flags are held, and dbg/step do not set.
- State machine:
  - IDLE: if any source is eligible, register the winner into the evt_* outputs and go to OFFER. evt_valid_o rises one cycle after the source becomes eligible.
  - OFFER: evt_valid_o=1 and type/cause are held stable. A newly arriving higher-priority source does not preempt; it stays pending.
    - Exception (EVT_IRQ offer): if irq_req_ctrl_i=0 and evt_ack_i=0, the offer is retracted and the state returns to IDLE next cycle.
    - On evt_ack_i=1: clear the matching pending flag(s), load cnt=PROGRESS_CNT, go to GUARD. evt_valid_o falls the next cycle.
  - GUARD: evt_valid_o=0. cnt decrements on each wb_valid_i and the state goes to IDLE when cnt reaches 0. A wb_valid_i in the same cycle as the ack is not counted.
- evt_ack_i while evt_valid_o=0 is ignored. This is an assertion error in simulation.
- Same-cycle events:
  - An error retiring in the ack cycle of a non-NMI event sets nmi_pend normally.
  - The ack of EVT_NMI clears nmi_pend before any same-cycle new error sets it, so a new error in that cycle re-pends. Same-cycle set wins.
- Counter: 4-bit, unsigned, no wrap. The decrement saturates at 0.
- evt_ack_i is sampled only on rising clk. Reset assertion mid-OFFER clears everything asynchronously.

Decomposition:
- event_type_e and the 4-bit counter width constant go into cv32e40x_pkg.
- No sub-module: a single FSM plus flag registers.
- cv32e40x_controller instantiates the block and routes evt_* to cv32e40x_controller_fsm.

Test Plan:
- IRQ take: irq_req_ctrl_i=1, irq_id_ctrl_i=11 -> next cycle evt_valid_o=1, type=EVT_IRQ, cause=11. Ack -> valid=0 until one wb_valid_i, then re-offered if the irq is still high.
- NMI priority: lsu_err_wb_i&wb_valid_i with addr 0x0000_1004, plus debug_req_i and irq in the same cycle -> offer EVT_NMI, nmi_addr_o=0x0000_1004. After ack and PROGRESS_CNT retirements -> EVT_DBG_REQ.
- No preemption and double error: during an EVT_IRQ offer, a bus error at 0x2000 then one at 0x3000 -> IRQ offer unchanged until ack. Next offer is NMI with addr 0x2000.
- IRQ retract: irq offer, irq_req_ctrl_i drops with no ack -> evt_valid_o=0 next cycle, state IDLE, no flags changed.
- Debug masking and step: debug_mode_i=1 with irq and debug_req_i pulsed -> no offer, dbg_pend not set. Then debug_mode_i=0, step=1, one retirement -> EVT_DBG_STEP.
- PROGRESS_CNT=3 and reset: after ack, two retirements -> no offer; third -> offer. rst_n low mid-OFFER -> all outputs at reset values immediately.
